// File: rtl/instr_fetch_if.sv
// Instruction-fetch bundle: imem handshake, pipeline control and IF/ID outputs.
// master = fetch stage, slave = memory/downstream side.
interface instr_fetch_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            valid;
  logic [XLEN-1:0] instr;
  logic [OPW-1:0]  opcode;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;

  modport master (
    output imem_req, imem_addr, valid, instr, opcode, pc_out, pc_plus4,
    input  imem_ack, imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, valid, instr, opcode, pc_out, pc_plus4,
    output imem_ack, imem_rdata, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, skid buffer and IF/ID register.
// Optional IFETCH_PERF_CNT_EN adds fetch_count / stall_count outputs.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   stall_count
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ifid_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  ifid_t           ifid_q, ifid_d;
  ifid_t           skid_q, skid_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            load_c;
  logic            accept_c;
  logic [XLEN-1:0] target_c;

  assign target_c = bus.branch_target & ALIGN_MASK;

  // Next-state, PC and IF/ID/skid update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    ifid_d   = ifid_q;
    skid_d   = skid_q;
    valid_d  = valid_q;
    load_c   = 1'b0;
    accept_c = 1'b0;

    // An unstalled downstream consumes the current word; it becomes a bubble unless refilled
    if (!bus.stall) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (bus.branch_taken) pc_d = target_c;
      end
      FETCH: begin
        if (bus.branch_taken) begin
          pc_d    = target_c;
          state_d = bus.imem_ack ? FETCH : DRAIN;
        end else if (bus.imem_ack) begin
          accept_c = 1'b1;
          pc_d     = pc_q + PC_STEP;
          if (bus.stall) begin
            skid_d  = '{instr: bus.imem_rdata, pc: pc_q};
            state_d = HOLD;
          end else begin
            ifid_d  = '{instr: bus.imem_rdata, pc: pc_q};
            valid_d = 1'b1;
            load_c  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.branch_taken) pc_d = target_c;
        if (bus.imem_ack) state_d = FETCH;
      end
      HOLD: begin
        if (bus.branch_taken) begin
          pc_d    = target_c;
          skid_d  = '0;
          state_d = FETCH;
        end else if (!bus.stall) begin
          ifid_d  = skid_q;
          valid_d = 1'b1;
          load_c  = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.branch_taken) valid_d = 1'b0;
    if (load_c) pc4_d = ifid_d.pc + PC_STEP;
    req_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  // State and datapath registers; reset also drops imem_req asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      ifid_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      ifid_q  <= ifid_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.valid     = valid_q;
  assign bus.instr     = ifid_q.instr;
  assign bus.opcode    = ifid_q.instr[31:26];
  assign bus.pc_out    = ifid_q.pc;
  assign bus.pc_plus4  = pc4_q;

`ifdef IFETCH_PERF_CNT_EN
  // Accepted-word and stalled-live-instruction counters, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept_c) fetch_count <= fetch_count + 32'd1;
      if (bus.stall && valid_q) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run
// against an instruction-stream scoreboard and a variable-latency memory model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.stall          = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.branch_target  = '0;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for imem_req; called on a negedge
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Answer the outstanding request after lat cycles; reports address and stability
  task automatic serve(input int lat, input logic [31:0] data,
                       output logic [31:0] addr, output bit stable);
    addr = bus.imem_addr;
    stable = 1'b1;
    bus.imem_ack = 1'b0;
    repeat (lat) begin
      tick();
      if (bus.imem_addr !== addr || bus.imem_req !== 1'b1) stable = 1'b0;
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    tick();
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a;
    bit st;
    rst = 1'b1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    repeat (2) tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b0, RESET_PC}) begin
      failures++;
      $display("FAIL reset_req_addr: got req=%b addr=%h expected req=0 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
    checks++;
    if ({bus.valid, bus.instr, bus.opcode, bus.pc_out, bus.pc_plus4} !== '0) begin
      failures++;
      $display("FAIL reset_ifid: got valid=%b instr=%h op=%h pc=%h pc4=%h expected all zero",
               bus.valid, bus.instr, bus.opcode, bus.pc_out, bus.pc_plus4);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
    serve(1, 32'h2008_0005, a, st);
    checks++;
    if (bus.valid !== 1'b1 || bus.instr !== 32'h2008_0005 || bus.opcode !== 6'b001000 ||
        bus.pc_out !== 32'h0 || bus.pc_plus4 !== 32'h4) begin
      failures++;
      $display("FAIL first_word: got v=%b instr=%h op=%b pc=%h pc4=%h expected v=1 instr=20080005 op=001000 pc=0 pc4=4",
               bus.valid, bus.instr, bus.opcode, bus.pc_out, bus.pc_plus4);
    end
    // Request to 4 is outstanding: reset must drop it without a clock edge
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got req=%b valid=%b expected req=0 valid=0", bus.imem_req, bus.valid);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] a;
    bit st, ok;
    do_reset();
    tick();
    wait_req(ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i)) begin
        failures++;
        $display("FAIL stream_req%0d: got req=%b addr=%h expected req=1 addr=%h", i, bus.imem_req, bus.imem_addr, 32'(4 * i));
      end
      serve(3, mem_word(32'(4 * i)), a, st);
      checks++;
      if (!st) begin
        failures++;
        $display("FAIL stream_addr_stable%0d: got unstable expected stable addr %h", i, a);
      end
      checks++;
      if (bus.valid !== 1'b1 || bus.instr !== mem_word(32'(4 * i)) || bus.pc_out !== 32'(4 * i)) begin
        failures++;
        $display("FAIL stream_word%0d: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=%h",
                 i, bus.valid, bus.instr, bus.pc_out, mem_word(32'(4 * i)), 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] a;
    bit st, ok;
    do_reset();
    tick();
    wait_req(ok);
    serve(1, mem_word(32'h0), a, st);
    serve(1, mem_word(32'h4), a, st);
    bus.stall = 1'b1;
    serve(2, mem_word(32'h8), a, st);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.imem_req !== 1'b0 || bus.valid !== 1'b1 || bus.pc_out !== 32'h4 || bus.instr !== mem_word(32'h4)) begin
        failures++;
        $display("FAIL hold%0d: got req=%b v=%b pc=%h instr=%h expected req=0 v=1 pc=4 instr=%h",
                 i, bus.imem_req, bus.valid, bus.pc_out, bus.instr, mem_word(32'h4));
      end
      if (i == 0) tick();
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.instr !== mem_word(32'h8) || bus.pc_out !== 32'h8 || bus.pc_plus4 !== 32'hC) begin
      failures++;
      $display("FAIL hold_release: got v=%b instr=%h pc=%h pc4=%h expected v=1 instr=%h pc=8 pc4=c",
               bus.valid, bus.instr, bus.pc_out, bus.pc_plus4, mem_word(32'h8));
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
      failures++;
      $display("FAIL hold_next_req: got req=%b addr=%h expected req=1 addr=c", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_branch_drain();
    logic [31:0] a;
    bit st, ok;
    do_reset();
    tick();
    wait_req(ok);
    for (int i = 0; i < 4; i++) serve(1, mem_word(32'(4 * i)), a, st);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    tick();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.valid !== 1'b0 || bus.imem_req !== 1'b1) begin
      failures++;
      $display("FAIL drain_enter: got v=%b req=%b expected v=0 req=1", bus.valid, bus.imem_req);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = mem_word(32'h10);
    tick();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL drain_discard: got v=%b req=%b addr=%h expected v=0 req=1 addr=40", bus.valid, bus.imem_req, bus.imem_addr);
    end
    serve(1, mem_word(32'h40), a, st);
    checks++;
    if (bus.valid !== 1'b1 || bus.instr !== mem_word(32'h40) || bus.pc_out !== 32'h40) begin
      failures++;
      $display("FAIL drain_target_word: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=40",
               bus.valid, bus.instr, bus.pc_out, mem_word(32'h40));
    end
  endtask

  task automatic test_branch_hold();
    logic [31:0] a;
    bit st, ok;
    do_reset();
    tick();
    wait_req(ok);
    serve(1, mem_word(32'h0), a, st);
    bus.stall = 1'b1;
    serve(1, mem_word(32'h4), a, st);
    checks++;
    if (bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL bhold_enter: got req=%b expected req=0", bus.imem_req);
    end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    tick();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL bhold_flush: got v=%b req=%b addr=%h expected v=0 req=1 addr=40", bus.valid, bus.imem_req, bus.imem_addr);
    end
    bus.stall = 1'b0;
    serve(2, mem_word(32'h40), a, st);
    checks++;
    if (bus.valid !== 1'b1 || bus.instr !== mem_word(32'h40) || bus.pc_out !== 32'h40) begin
      failures++;
      $display("FAIL bhold_target_word: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=40",
               bus.valid, bus.instr, bus.pc_out, mem_word(32'h40));
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] a;
    bit st, ok;
    do_reset();
    tick();
    wait_req(ok);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFE;
    tick();
    bus.branch_taken = 1'b0;
    bus.imem_ack     = 1'b1;
    bus.imem_rdata   = mem_word(32'h0);
    tick();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_req: got req=%b addr=%h expected req=1 addr=fffffffc", bus.imem_req, bus.imem_addr);
    end
    serve(1, mem_word(32'hFFFF_FFFC), a, st);
    checks++;
    if (bus.valid !== 1'b1 || bus.pc_out !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0 || bus.imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_word: got v=%b pc=%h pc4=%h addr=%h expected v=1 pc=fffffffc pc4=0 addr=0",
               bus.valid, bus.pc_out, bus.pc_plus4, bus.imem_addr);
    end
`ifdef IFETCH_PERF_CNT_EN
    checks++;
    if (fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL wrap_fetch_count: got %0d expected 1", fetch_count);
    end
    bus.stall = 1'b1;
    repeat (3) tick();
    bus.stall = 1'b0;
    tick();
    checks++;
    if (stall_count !== 32'd3) begin
      failures++;
      $display("FAIL wrap_stall_count: got %0d expected 3", stall_count);
    end
`endif
  endtask

  // Random run: the decoder must see the architectural stream, one word per consumption
  task automatic test_random();
    logic [31:0] exp_next, pend_addr, addr_l, tgt, w;
    bit busy, tainted, pend, exp_v0, do_br, do_ack;
    int rem, consumed, idle, accepted, stalled_valid;
    do_reset();
    exp_next = RESET_PC;
    busy = 0; tainted = 0; pend = 0; exp_v0 = 0;
    rem = 0; consumed = 0; idle = 0; accepted = 0; stalled_valid = 0;
    pend_addr = '0; addr_l = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (exp_v0) begin
        checks++;
        if (bus.valid !== 1'b0) begin
          failures++;
          $display("FAIL rnd_flush cyc=%0d: got valid=%b expected 0", cyc, bus.valid);
        end
        exp_v0 = 0;
      end
      if (!busy && bus.imem_req === 1'b1) begin
        busy = 1; tainted = 0;
        addr_l = bus.imem_addr;
        rem = int'($urandom_range(1, 4));
        if (pend) begin
          checks++;
          if (addr_l !== pend_addr) begin
            failures++;
            $display("FAIL rnd_branch_req cyc=%0d: got addr=%h expected %h", cyc, addr_l, pend_addr);
          end
          pend = 0;
        end
      end else if (busy && !tainted) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr_l) begin
          failures++;
          $display("FAIL rnd_addr_stable cyc=%0d: got req=%b addr=%h expected req=1 addr=%h", cyc, bus.imem_req, bus.imem_addr, addr_l);
        end
      end
      do_ack = 0;
      if (busy) begin
        if (rem == 0) do_ack = 1;
        else rem--;
      end
      bus.stall = ($urandom_range(0, 9) < 3);
      do_br = (cyc > 2) && ($urandom_range(0, 24) == 0);
      tgt = $urandom();
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF5;
      bus.branch_taken  = do_br;
      bus.branch_target = tgt;
      bus.imem_ack      = do_ack;
      bus.imem_rdata    = do_ack ? mem_word(addr_l) : $urandom();
      if (bus.valid === 1'b1 && !bus.stall) begin
        consumed++;
        idle = 0;
        w = mem_word(exp_next);
        checks++;
        if (bus.pc_out !== exp_next || bus.instr !== w || bus.opcode !== w[31:26] || bus.pc_plus4 !== exp_next + 32'd4) begin
          failures++;
          $display("FAIL rnd_stream cyc=%0d: got pc=%h instr=%h op=%h pc4=%h expected pc=%h instr=%h op=%h pc4=%h",
                   cyc, bus.pc_out, bus.instr, bus.opcode, bus.pc_plus4, exp_next, w, w[31:26], exp_next + 32'd4);
        end
        exp_next = bus.pc_out + 32'd4;
      end else begin
        idle++;
      end
      if (bus.stall && bus.valid === 1'b1) stalled_valid++;
      if (do_ack) begin
        busy = 0;
        if (!tainted && !do_br) accepted++;
      end
      if (do_br) begin
        exp_next = tgt & ~32'd3;
        pend = 1;
        pend_addr = exp_next;
        exp_v0 = 1;
        if (busy) tainted = 1;
      end
      if (idle > 300) begin
        failures++;
        $display("FAIL rnd_timeout cyc=%0d: got no consumption for %0d cycles expected progress", cyc, idle);
        break;
      end
      tick();
    end
    bus.imem_ack = 1'b0;
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    checks++;
    if (consumed < 200) begin
      failures++;
      $display("FAIL rnd_throughput: got %0d consumed expected at least 200", consumed);
    end
`ifdef IFETCH_PERF_CNT_EN
    checks++;
    if (fetch_count !== 32'(accepted)) begin
      failures++;
      $display("FAIL rnd_fetch_count: got %0d expected %0d", fetch_count, accepted);
    end
    checks++;
    if (stall_count !== 32'(stalled_valid)) begin
      failures++;
      $display("FAIL rnd_stall_count: got %0d expected %0d", stall_count, stalled_valid);
    end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    tick();
    test_reset();
    test_stream();
    test_stall_hold();
    test_branch_drain();
    test_branch_hold();
    test_pc_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage that sits directly upstream of the main control decoder. It holds the PC and fetches words over a variable-latency instruction-memory handshake. Each fetched word goes into an IF/ID output register that supplies the 6-bit opcode to the decoder and the full instruction, PC and PC+4 to the rest of the datapath. It supports downstream stall, branch redirect with flush, and discard of in-flight fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; high in FETCH and DRAIN.
- imem_addr  out  32  fetch address, equal to internal pc; stable while imem_req high until imem_ack.
- imem_ack  in  1  one-cycle pulse, rdata valid; earliest the cycle after imem_req first rises.
- imem_rdata  in  32  instruction word, sampled when imem_ack=1.
- stall  in  1  downstream cannot accept; IF/ID register holds.
- branch_taken  in  1  redirect/flush request, single cycle.
- branch_target  in  32  new PC, sampled when branch_taken=1.
- valid  out  1  IF/ID contents are a live instruction.
- instr  out  32  fetched instruction.
- opcode  out  6  instr[31:26], to control decoder.
- pc_out  out  32  address of instr.
- pc_plus4  out  32  pc_out + 4 (mod 2^32).

## Operation
- States: IDLE, FETCH (request outstanding), DRAIN (request outstanding, result to be discarded), HOLD (word captured in skid buffer, output stalled).
- Accepting a word means an imem_ack seen in FETCH that is neither flushed nor dropped.
- IDLE: next state FETCH unconditionally.
- FETCH, imem_ack=1, branch_taken=0, stall=0:
  - load IF/ID with {imem_rdata, pc}; valid=1.
  - pc <= pc+4; stay FETCH (new address presented next cycle).
- FETCH, imem_ack=1, branch_taken=0, stall=1:
  - capture {rdata, pc} in skid buffer; pc <= pc+4; go HOLD.
  - IF/ID unchanged.
- FETCH, imem_ack=0, branch_taken=1: pc <= branch_target; valid <= 0; go DRAIN.
- FETCH, imem_ack=1, branch_taken=1: rdata discarded; pc <= branch_target; valid <= 0; stay FETCH.
- DRAIN, imem_ack=1: discard rdata; go FETCH.
- DRAIN, branch_taken=1: pc <= branch_target (latest wins); valid <= 0.
- HOLD, stall=0: move buffer into IF/ID, valid=1; go FETCH.
- HOLD, branch_taken=1: buffer discarded; valid <= 0; pc <= branch_target; go FETCH.
- Branch priority: branch_taken overrides stall; flush clears valid even while stalled.
- stall=1 with no ack or branch: IF/ID holds; valid unchanged.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- Low two bits of branch_target are forced to 0.

## Timing
- Reset values:
  - state=IDLE; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC.
  - valid=0; instr=0; opcode=0; pc_out=0; pc_plus4=0; skid buffer cleared.
- imem_req first high one cycle after rst deasserts.
- Ack-to-output latency: 1 cycle. IF/ID updates on the edge that samples imem_ack; valid is visible the following cycle.
- Peak throughput: one instruction per (memory latency + 0) cycles; back-to-back requests have no bubble.
- A branch asserted in cycle N: valid=0 from N+1. In FETCH with ack, or in HOLD, the request to branch_target is issued in N+1.
- opcode and pc_plus4 are registered alongside instr; no combinational path from imem_rdata to outputs.
- rst asserted mid-fetch: an outstanding request is abandoned immediately and imem_req drops asynchronously. The memory model must tolerate the abandoned request.

## Configuration
- IFETCH_PERF_CNT_EN defined: two added outputs.
  - fetch_count out 32: increments per accepted word.
  - stall_count out 32: increments each cycle stall=1 and valid=1.
  - Both reset to 0 and wrap at 2^32.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, 1-cycle-latency memory returning 32'h2008_0005: imem_req rises cycle 1, addr 0 -> instr=32'h2008_0005, opcode=6'b001000, pc_out=0, pc_plus4=4, valid=1.
- Streaming, 3-cycle latency, addresses 0,4,8 -> three accepted words in order; imem_addr stable during each wait.
- stall=1 for 4 cycles while ack arrives for addr 8 -> HOLD, imem_req=0, IF/ID holds the addr-4 word; stall release -> addr-8 word appears next cycle, fetch of 12 follows.
- branch_taken with target 32'h40 while request to 0x10 is outstanding -> valid=0 next cycle, DRAIN; ack for 0x10 discarded; next request addr 0x40.
- branch_taken with stall=1 in HOLD -> valid=0, buffer dropped, next request 32'h40.
- pc at 32'hFFFF_FFFC accepted -> next imem_addr=0, pc_plus4=0; with IFETCH_PERF_CNT_EN, fetch_count matches accepted words.
